// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the sys_ctrl command controller.
//   - Host command codes that open a frame in IDLE.
//   - FSM state encoding (12 states, 4 bits).
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;  // addr, data
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;  // addr
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // A, B, FUN
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // FUN

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_RD_SEND  = 4'd5,
    S_ALU_A    = 4'd6,
    S_ALU_B    = 4'd7,
    S_ALU_FUN  = 4'd8,
    S_ALU_WAIT = 4'd9,
    S_SEND_LO  = 4'd10,
    S_SEND_HI  = 4'd11
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// sys_ctrl: REF_CLK-domain command controller. Decodes RX byte frames,
// sequences register-file writes/reads and ALU operations, and pushes
// response bytes into the TX FIFO.
//
// Ports:
//   CLK, RST           clock, async active-low reset
//   RX_P_DATA/RX_D_VLD received byte and its one-cycle strobe
//   ALU_OUT/OUT_VALID  ALU result and its valid flag
//   RdData             RF read data, valid the cycle after RdEn
//   FULL               TX FIFO full
//   Address/WrEn/RdEn/WrData  RF access (strobes are one-cycle pulses)
//   ALU_FUN/CLK_GATE_EN       ALU function and clock-gate enable
//   WR_DATA/W_INC             TX FIFO write data and push strobe
// All outputs are registered.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int OPA_ADDR   = 0,
  parameter int OPB_ADDR   = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    FULL,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    W_INC
);

  state_e                  state, state_nxt;
  logic [2*DATA_WIDTH-1:0] res, res_nxt;
  logic                    rd_fresh, rd_fresh_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    wr_en_nxt, rd_en_nxt, gate_nxt, w_inc_nxt;
  logic [DATA_WIDTH-1:0]   wr_data_nxt, fifo_data_nxt;
  logic [FUN_WIDTH-1:0]    fun_nxt;

  // Shared FIFO push request: any SEND state raises send_req with the byte
  // to push and the state to move to once the FIFO accepts it.
  logic                    send_req;
  logic [DATA_WIDTH-1:0]   send_byte;
  state_e                  send_next;

  always_comb begin
    state_nxt     = state;
    res_nxt       = res;
    rd_fresh_nxt  = 1'b0;
    addr_nxt      = Address;
    wr_en_nxt     = 1'b0;
    rd_en_nxt     = 1'b0;
    wr_data_nxt   = WrData;
    fun_nxt       = ALU_FUN;
    gate_nxt      = CLK_GATE_EN;
    fifo_data_nxt = WR_DATA;
    w_inc_nxt     = 1'b0;
    send_req      = 1'b0;
    send_byte     = res[DATA_WIDTH-1:0];
    send_next     = S_IDLE;

    case (state)
      S_IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_RF_WR:   state_nxt = S_WR_ADDR;
          CMD_RF_RD:   state_nxt = S_RD_ADDR;
          CMD_ALU_OP:  state_nxt = S_ALU_A;
          CMD_ALU_NOP: state_nxt = S_ALU_FUN;
          default:     state_nxt = S_IDLE;
        endcase
      end
      S_WR_ADDR: if (RX_D_VLD) begin
        addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_nxt = S_WR_DATA;
      end
      S_WR_DATA: if (RX_D_VLD) begin
        wr_en_nxt   = 1'b1;
        wr_data_nxt = RX_P_DATA;
        state_nxt   = S_IDLE;
      end
      S_RD_ADDR: if (RX_D_VLD) begin
        rd_en_nxt = 1'b1;
        addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_fresh_nxt = 1'b1;
        state_nxt    = S_RD_SEND;
      end
      // RdData is only valid on the first RD_SEND cycle: forward it directly
      // then, and keep a copy in res for any FULL stall that follows.
      S_RD_SEND: begin
        send_req  = 1'b1;
        send_next = S_IDLE;
        if (rd_fresh) begin
          send_byte                = RdData;
          res_nxt[DATA_WIDTH-1:0] = RdData;
        end
      end
      S_ALU_A: if (RX_D_VLD) begin
        wr_en_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(OPA_ADDR);
        wr_data_nxt = RX_P_DATA;
        state_nxt   = S_ALU_B;
      end
      S_ALU_B: if (RX_D_VLD) begin
        wr_en_nxt   = 1'b1;
        addr_nxt    = ADDR_WIDTH'(OPB_ADDR);
        wr_data_nxt = RX_P_DATA;
        state_nxt   = S_ALU_FUN;
      end
      S_ALU_FUN: if (RX_D_VLD) begin
        fun_nxt   = RX_P_DATA[FUN_WIDTH-1:0];
        gate_nxt  = 1'b1;
        state_nxt = S_ALU_WAIT;
      end
      // OUT_VALID is honoured from the very first gated cycle.
      S_ALU_WAIT: if (OUT_VALID) begin
        res_nxt   = ALU_OUT;
        gate_nxt  = 1'b0;
        state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        send_req  = 1'b1;
        send_byte = res[DATA_WIDTH-1:0];
        send_next = S_SEND_HI;
      end
      S_SEND_HI: begin
        send_req  = 1'b1;
        send_byte = res[2*DATA_WIDTH-1:DATA_WIDTH];
        send_next = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // While FULL, the state holds and WR_DATA keeps its previous value.
    if (send_req && !FULL) begin
      w_inc_nxt     = 1'b1;
      fifo_data_nxt = send_byte;
      state_nxt     = send_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      res         <= '0;
      rd_fresh    <= 1'b0;
      Address     <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      WrData      <= '0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      WR_DATA     <= '0;
      W_INC       <= 1'b0;
    end else begin
      state       <= state_nxt;
      res         <= res_nxt;
      rd_fresh    <= rd_fresh_nxt;
      Address     <= addr_nxt;
      WrEn        <= wr_en_nxt;
      RdEn        <= rd_en_nxt;
      WrData      <= wr_data_nxt;
      ALU_FUN     <= fun_nxt;
      CLK_GATE_EN <= gate_nxt;
      WR_DATA     <= fifo_data_nxt;
      W_INC       <= w_inc_nxt;
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: self-checking bench for sys_ctrl. Surrounding blocks (RF, ALU,
// TX FIFO) are modelled behaviourally; expected RF contents and FIFO bytes
// come from a command-level reference model.
`timescale 1ns/1ps
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] ALU_OUT = 16'h0000;
  logic        OUT_VALID = 1'b0;
  logic [7:0]  RdData = 8'h00;
  logic        FULL = 1'b0;
  logic [3:0]  Address;
  logic        WrEn, RdEn, CLK_GATE_EN, W_INC;
  logic [7:0]  WrData, WR_DATA;
  logic [3:0]  ALU_FUN;

  always #5 CLK = ~CLK;

  sys_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .RdData(RdData), .FULL(FULL),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .WR_DATA(WR_DATA), .W_INC(W_INC)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Environment models
  logic [7:0]  rf_mem [16] = '{default: 8'h00};
  logic [7:0]  fifo_q [$];
  int          push_cyc [$];
  int          cyc = 0, wr_cnt = 0, rd_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [3:0]  rd_addr = 4'h0;
  int          alu_lat = 2, gate_cnt = 0;
  logic        alu_force_en = 1'b0;
  logic [15:0] alu_force = 16'h0000;
  logic        full_force = 1'b0, full_rand = 1'b0;

  // Reference model
  logic [7:0]  exp_rf [16] = '{default: 8'h00};
  logic [7:0]  exp_q [$];

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      4'd3:    return {a, b};
      default: return {8'h00, a ^ b};
    endcase
  endfunction

  // RF + FIFO observer, just after each rising edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (rd_pend) RdData = rf_mem[rd_addr];
    rd_pend = RdEn;
    rd_addr = Address;
    if (WrEn) begin rf_mem[Address] = WrData; wr_cnt++; end
    if (RdEn) rd_cnt++;
    if (W_INC) begin fifo_q.push_back(WR_DATA); push_cyc.push_back(cyc); end
  end

  // ALU and FIFO-full drivers.
  always @(posedge CLK) begin
    #2;
    FULL = full_rand ? ($urandom_range(0, 2) == 0) : full_force;
    if (!CLK_GATE_EN) begin
      gate_cnt  = 0;
      OUT_VALID = 1'b0;
    end else begin
      OUT_VALID = (gate_cnt == alu_lat);
      if (OUT_VALID) ALU_OUT = alu_force_en ? alu_force : alu_fn(rf_mem[0], rf_mem[1], ALU_FUN);
      gate_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_ov(input string name);
    int to = 0;
    while (OUT_VALID !== 1'b1 && to < 60) begin tick(1); to++; end
    n_chk++;
    if (OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL %s_ov_timeout: OUT_VALID=%b expected 1", name, OUT_VALID);
    end
  endtask

  task automatic wait_pushes(input string name, input int target);
    int to = 0;
    while (fifo_q.size() < target && to < 200) begin tick(1); to++; end
    n_chk++;
    if (fifo_q.size() < target) begin
      n_fail++; $display("FAIL %s_push_timeout: pushes=%0d expected %0d", name, fifo_q.size(), target);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    tick(2);
    n_chk++;
    if ({WrEn, RdEn, W_INC, CLK_GATE_EN, Address, WrData, ALU_FUN, WR_DATA} !== 28'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0",
        {WrEn, RdEn, W_INC, CLK_GATE_EN, Address, WrData, ALU_FUN, WR_DATA});
    end
    RST = 1'b1;
    tick(2);
  endtask

  task automatic test_rf_write();
    int w0 = wr_cnt;
    int p0 = fifo_q.size();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    exp_rf[5] = 8'h3C;
    n_chk++;
    if (WrEn !== 1'b1 || Address !== 4'h5 || WrData !== 8'h3C) begin
      n_fail++; $display("FAIL rf_write_pulse: WrEn=%b Addr=%h Data=%h expected 1/5/3c", WrEn, Address, WrData);
    end
    tick(1);
    n_chk++;
    if (WrEn !== 1'b0) begin n_fail++; $display("FAIL rf_write_width: WrEn=%b expected 0", WrEn); end
    tick(2);
    n_chk++;
    if (wr_cnt - w0 != 1 || fifo_q.size() != p0) begin
      n_fail++; $display("FAIL rf_write_count: writes=%0d pushes=%0d expected 1/0", wr_cnt - w0, fifo_q.size() - p0);
    end
    n_chk++;
    if (rf_mem[5] !== exp_rf[5]) begin
      n_fail++; $display("FAIL rf_write_mem: got %h expected %h", rf_mem[5], exp_rf[5]);
    end
  endtask

  task automatic test_rf_read();
    int p0;
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
    exp_rf[7] = 8'h99;
    p0 = fifo_q.size();
    send_byte(8'hBB); send_byte(8'h07);
    n_chk++;
    if (RdEn !== 1'b1 || Address !== 4'h7) begin
      n_fail++; $display("FAIL rd_pulse: RdEn=%b Addr=%h expected 1/7", RdEn, Address);
    end
    tick(1);
    n_chk++;
    if (RdEn !== 1'b0 || W_INC !== 1'b0) begin
      n_fail++; $display("FAIL rd_width: RdEn=%b W_INC=%b expected 0/0", RdEn, W_INC);
    end
    tick(1);
    n_chk++;
    if (W_INC !== 1'b1 || WR_DATA !== 8'h99) begin
      n_fail++; $display("FAIL rd_push: W_INC=%b WR_DATA=%h expected 1/99", W_INC, WR_DATA);
    end
    tick(3);
    n_chk++;
    if (fifo_q.size() != p0 + 1) begin
      n_fail++; $display("FAIL rd_push_count: got %0d expected 1", fifo_q.size() - p0);
    end
  endtask

  task automatic test_alu_ops();
    int p0, ov_cyc;
    logic [15:0] r;
    alu_lat = 2;
    send_byte(8'hCC); send_byte(8'h0A);
    n_chk++;
    if (WrEn !== 1'b1 || Address !== 4'h0 || WrData !== 8'h0A) begin
      n_fail++; $display("FAIL alu_opa: WrEn=%b Addr=%h Data=%h expected 1/0/0a", WrEn, Address, WrData);
    end
    send_byte(8'h03);
    n_chk++;
    if (WrEn !== 1'b1 || Address !== 4'h1 || WrData !== 8'h03) begin
      n_fail++; $display("FAIL alu_opb: WrEn=%b Addr=%h Data=%h expected 1/1/03", WrEn, Address, WrData);
    end
    exp_rf[0] = 8'h0A; exp_rf[1] = 8'h03;
    r = alu_fn(8'h0A, 8'h03, 4'd0);
    p0 = fifo_q.size();
    send_byte(8'h00);
    n_chk++;
    if (CLK_GATE_EN !== 1'b1 || ALU_FUN !== 4'h0) begin
      n_fail++; $display("FAIL alu_gate_on: gate=%b fun=%h expected 1/0", CLK_GATE_EN, ALU_FUN);
    end
    wait_ov("alu");
    ov_cyc = cyc;
    n_chk++;
    if (CLK_GATE_EN !== 1'b1) begin n_fail++; $display("FAIL alu_gate_hold: gate=%b expected 1", CLK_GATE_EN); end
    tick(1);
    n_chk++;
    if (CLK_GATE_EN !== 1'b0) begin n_fail++; $display("FAIL alu_gate_off: gate=%b expected 0", CLK_GATE_EN); end
    wait_pushes("alu", p0 + 2);
    if (fifo_q.size() >= p0 + 2) begin
      n_chk++;
      if (fifo_q[p0] !== r[7:0] || fifo_q[p0+1] !== r[15:8]) begin
        n_fail++; $display("FAIL alu_bytes: got %h %h expected %h %h", fifo_q[p0], fifo_q[p0+1], r[7:0], r[15:8]);
      end
      n_chk++;
      if (push_cyc[p0] - ov_cyc < 1 || push_cyc[p0] - ov_cyc > 2 || push_cyc[p0+1] != push_cyc[p0] + 1) begin
        n_fail++; $display("FAIL alu_push_timing: first=+%0d second=+%0d expected +1..2 then consecutive",
          push_cyc[p0] - ov_cyc, push_cyc[p0+1] - ov_cyc);
      end
    end
  endtask

  task automatic test_fifo_full();
    int p0;
    logic [7:0] hold;
    full_force = 1'b1; alu_force_en = 1'b1; alu_force = 16'h1234; alu_lat = 1;
    p0 = fifo_q.size();
    send_byte(8'hDD); send_byte(8'h02);
    wait_ov("full");
    tick(1);
    hold = WR_DATA;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (W_INC !== 1'b0 || WR_DATA !== hold) begin
        n_fail++; $display("FAIL full_hold: W_INC=%b WR_DATA=%h expected 0/%h", W_INC, WR_DATA, hold);
      end
      tick(1);
    end
    full_force = 1'b0;
    wait_pushes("full", p0 + 2);
    tick(4);
    n_chk++;
    if (fifo_q.size() != p0 + 2) begin
      n_fail++; $display("FAIL full_count: pushes=%0d expected 2", fifo_q.size() - p0);
    end else begin
      n_chk++;
      if (fifo_q[p0] !== 8'h34 || fifo_q[p0+1] !== 8'h12 || push_cyc[p0+1] != push_cyc[p0] + 1) begin
        n_fail++; $display("FAIL full_bytes: got %h %h expected 34 12", fifo_q[p0], fifo_q[p0+1]);
      end
    end
    n_chk++;
    if (ALU_FUN !== 4'h2) begin n_fail++; $display("FAIL full_fun_hold: got %h expected 2", ALU_FUN); end
    alu_force_en = 1'b0;
  endtask

  task automatic test_robust();
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    int p0 = fifo_q.size();
    logic [15:0] r;
    send_byte(8'h5A);
    tick(2);
    n_chk++;
    if (wr_cnt != w0 || rd_cnt != r0 || CLK_GATE_EN !== 1'b0 || fifo_q.size() != p0) begin
      n_fail++; $display("FAIL junk_ignored: wr=%0d rd=%0d gate=%b expected 0/0/0", wr_cnt - w0, rd_cnt - r0, CLK_GATE_EN);
    end
    alu_lat = 6;
    r = alu_fn(exp_rf[0], exp_rf[1], 4'd0);
    send_byte(8'hDD); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h11);
    n_chk++;
    if (CLK_GATE_EN !== 1'b1) begin n_fail++; $display("FAIL busy_gate: gate=%b expected 1", CLK_GATE_EN); end
    wait_pushes("busy", p0 + 2);
    tick(1);
    n_chk++;
    if (fifo_q.size() != p0 + 2 || wr_cnt != w0 || rd_cnt != r0) begin
      n_fail++; $display("FAIL busy_count: pushes=%0d wr=%0d rd=%0d expected 2/0/0", fifo_q.size() - p0, wr_cnt - w0, rd_cnt - r0);
    end else begin
      n_chk++;
      if (fifo_q[p0] !== r[7:0] || fifo_q[p0+1] !== r[15:8]) begin
        n_fail++; $display("FAIL busy_bytes: got %h %h expected %h %h", fifo_q[p0], fifo_q[p0+1], r[7:0], r[15:8]);
      end
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
    exp_rf[1] = 8'hFF;
    n_chk++;
    if (WrEn !== 1'b1 || Address !== 4'h1 || WrData !== 8'hFF) begin
      n_fail++; $display("FAIL after_busy_write: WrEn=%b Addr=%h Data=%h expected 1/1/ff", WrEn, Address, WrData);
    end
    tick(1);
  endtask

  task automatic test_reset_mid();
    int w0, r0, p0;
    alu_lat = 20;
    send_byte(8'hDD); send_byte(8'h03);
    tick(2);
    #2 RST = 1'b0;
    #1;
    n_chk++;
    if ({WrEn, RdEn, W_INC, CLK_GATE_EN, Address, WrData, ALU_FUN, WR_DATA} !== 28'h0) begin
      n_fail++; $display("FAIL async_reset: got %h expected 0",
        {WrEn, RdEn, W_INC, CLK_GATE_EN, Address, WrData, ALU_FUN, WR_DATA});
    end
    @(negedge CLK);
    tick(1);
    RST = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt; p0 = fifo_q.size();
    tick(25);
    n_chk++;
    if (wr_cnt != w0 || rd_cnt != r0 || fifo_q.size() != p0 || CLK_GATE_EN !== 1'b0) begin
      n_fail++; $display("FAIL reset_stray: wr=%0d rd=%0d push=%0d gate=%b expected 0/0/0/0",
        wr_cnt - w0, rd_cnt - r0, fifo_q.size() - p0, CLK_GATE_EN);
    end
    alu_lat = 2;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h77);
    exp_rf[2] = 8'h77;
    n_chk++;
    if (WrEn !== 1'b1 || Address !== 4'h2 || WrData !== 8'h77) begin
      n_fail++; $display("FAIL reset_recover: WrEn=%b Addr=%h Data=%h expected 1/2/77", WrEn, Address, WrData);
    end
    tick(1);
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    if ($urandom_range(0, 2) == 0) tick(1);
  endtask

  task automatic test_random();
    logic [7:0] a, b, d, f;
    logic [15:0] r;
    full_rand = 1'b1;
    fifo_q.delete(); push_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      send_gap(8'hAA); send_gap(8'(i)); send_gap(d);
      exp_rf[i] = d;
    end
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          a = 8'($urandom); d = 8'($urandom);
          send_gap(8'hAA); send_gap(a); send_gap(d);
          exp_rf[a[3:0]] = d;
        end
        1: begin
          a = 8'($urandom);
          exp_q.push_back(exp_rf[a[3:0]]);
          send_gap(8'hBB); send_byte(a);
          wait_pushes("rand_rd", exp_q.size());
        end
        2: begin
          a = 8'($urandom); b = 8'($urandom); f = 8'($urandom);
          alu_lat = $urandom_range(0, 3);
          exp_rf[0] = a; exp_rf[1] = b;
          r = alu_fn(a, b, f[3:0]);
          exp_q.push_back(r[7:0]); exp_q.push_back(r[15:8]);
          send_gap(8'hCC); send_gap(a); send_gap(b); send_byte(f);
          wait_pushes("rand_alu", exp_q.size());
        end
        3: begin
          f = 8'($urandom);
          alu_lat = $urandom_range(0, 3);
          r = alu_fn(exp_rf[0], exp_rf[1], f[3:0]);
          exp_q.push_back(r[7:0]); exp_q.push_back(r[15:8]);
          send_gap(8'hDD); send_byte(f);
          wait_pushes("rand_nop", exp_q.size());
        end
        default: begin
          do d = 8'($urandom); while (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD);
          send_gap(d);
        end
      endcase
    end
    full_rand = 1'b0;
    tick(6);
    n_chk++;
    if (fifo_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_push_count: got %0d expected %0d", fifo_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < fifo_q.size(); i++) begin
      n_chk++;
      if (fifo_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_push[%0d]: got %h expected %h", i, fifo_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (rf_mem[i] !== exp_rf[i]) begin
        n_fail++; $display("FAIL rand_rf[%0d]: got %h expected %h", i, rf_mem[i], exp_rf[i]);
      end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_rf_write();
    test_rf_read();
    test_alu_ops();
    test_fifo_full();
    test_robust();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command-level controller between the UART RX frame path and the register file / ALU / TX FIFO.
- Decodes byte frames from the REF_CLK-domain RX data synchronizer and sequences register-file writes and reads, ALU operations and ALU clock-gate enable.
- Pushes response bytes into the async FIFO that feeds UART TX.
- Single FSM in the REF_CLK domain.

Parameters:
- DATA_WIDTH, 8, width of RX frames, RF data and FIFO data.
- ADDR_WIDTH, 4, RF address width.
- FUN_WIDTH, 4, ALU function code width.
- OPA_ADDR, 0, RF address that receives ALU operand A.
- OPB_ADDR, 1, RF address that receives ALU operand B.

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  Asynchronous, active-low reset.
- RX_P_DATA  in  DATA_WIDTH  Synchronized RX frame.
- RX_D_VLD  in  1  One-cycle strobe; RX_P_DATA is valid this cycle.
- ALU_OUT  in  2*DATA_WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid.
- RdData  in  DATA_WIDTH  RF read data, valid the cycle after RdEn.
- FULL  in  1  TX FIFO full.
- Address  out  ADDR_WIDTH  RF address.
- WrEn  out  1  RF write strobe.
- RdEn  out  1  RF read strobe.
- WrData  out  DATA_WIDTH  RF write data.
- ALU_FUN  out  FUN_WIDTH  ALU function code.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- WR_DATA  out  DATA_WIDTH  FIFO write data.
- W_INC  out  1  FIFO push strobe.

Behaviour:
- Reset: all outputs 0, FSM in IDLE; result/capture registers 0.
- Reset asserted mid-command aborts the command; no partial strobe is issued after release.
- All outputs are registered.
- WrEn, RdEn and W_INC are exactly one-cycle pulses, asserted in the cycle after the accepting edge.
- Command codes, valid only in IDLE:
  - 0xAA: RF write. Next two bytes are addr, then data.
  - 0xBB: RF read. Next byte is addr.
  - 0xCC: ALU with operands. Next three bytes are A, B, FUN.
  - 0xDD: ALU without operands. Next byte is FUN.
  - Any other byte in IDLE is ignored (FSM stays IDLE, no outputs).
- Bytes are consumed only on RX_D_VLD=1; waiting states hold indefinitely between bytes.
- States and transitions:
  - IDLE -> WR_ADDR | RD_ADDR | ALU_A | ALU_FUN on the matching command code.
  - WR_ADDR -> WR_DATA: latch addr[ADDR_WIDTH-1:0]; upper bits are discarded.
  - WR_DATA -> IDLE: pulse WrEn with Address=addr, WrData=byte.
  - RD_ADDR -> RD_WAIT: pulse RdEn with Address=byte.
  - RD_WAIT -> RD_SEND: capture RdData one cycle later.
  - RD_SEND -> IDLE: when FULL=0, pulse W_INC with WR_DATA=captured byte.
  - ALU_A -> ALU_B: pulse WrEn to OPA_ADDR.
  - ALU_B -> ALU_FUN: pulse WrEn to OPB_ADDR.
  - ALU_FUN -> ALU_WAIT: latch ALU_FUN=byte[FUN_WIDTH-1:0]; assert CLK_GATE_EN.
  - ALU_WAIT -> SEND_LO: on OUT_VALID, capture ALU_OUT; deassert CLK_GATE_EN next cycle.
  - SEND_LO -> SEND_HI: when FULL=0, push ALU_OUT[7:0].
  - SEND_HI -> IDLE: when FULL=0, push ALU_OUT[15:8].
- CLK_GATE_EN is high only from entry to ALU_WAIT through the cycle OUT_VALID is seen.
- The ALU_OUT capture occurs even if OUT_VALID coincides with the first gated cycle.
- FULL=1 in any SEND state: W_INC held 0, WR_DATA stable, state holds. No byte is dropped or duplicated.
- RX_D_VLD in RD_WAIT, RD_SEND, ALU_WAIT, SEND_LO or SEND_HI is ignored; the byte is lost by design (host is half-duplex).
- RX_D_VLD in the same cycle that WrEn pulses is accepted by the next state; back-to-back frames need no gap.
- ALU_FUN holds its last value after the operation; it is reset to 0 only by RST.
- Latency, values measured as the cycle after the final byte's strobe, FIFO not full:
  - WrEn: +1.
  - RdEn: +1.
  - Read response push: +3.
  - ALU response: first push 1 cycle after OUT_VALID is seen; second push on the following cycle.

Decomposition:
- Package sys_ctrl_pkg holds:
  - Command constants CMD_RF_WR=8'hAA, CMD_RF_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD.
  - State enum (12 states, 4-bit encoding).
- No sub-module: a single FSM with output and capture registers.
- FIFO push logic is shared by the RD_SEND, SEND_LO and SEND_HI states.

Test Plan:
- RF write: bytes AA,05,3C -> WrEn one-cycle pulse with Address=5, WrData=3C; no W_INC; back in IDLE.
- RF read: AA,07,99 then BB,07, model returns 99 -> RdEn pulse with Address=7; W_INC once with WR_DATA=99.
- ALU with operands: CC,0A,03,00 (add), model ALU_OUT=000D after 2 cycles -> WrEn to addr 0 (0A), then addr 1 (03); CLK_GATE_EN high until OUT_VALID; pushes 0D then 00.
- FIFO full: DD,02, ALU_OUT=1234, FULL held 1 for 5 cycles then 0 -> no W_INC while FULL=1; then pushes 34, 12 exactly once each.
- Robustness: unknown byte 5A, then RX bytes during ALU_WAIT -> ignored; FSM returns to IDLE and the next AA,01,FF is executed correctly.
- Reset mid-operation: RST low during ALU_WAIT -> all outputs 0 asynchronously; after release, no stray strobes and IDLE accepts a new command.
